// File: rtl/vga_sync_gen.sv
// VGA sync generator. A single original_clk domain advances the horizontal and
// vertical pixel counters on each pixel_en strobe. All sync and timing outputs
// are decoded from the next-state counts and registered alongside them, so they
// line up exactly with pixel_x/pixel_y.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       original_clk,
  input  logic       reset,
  input  logic       pixel_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start
);

  typedef logic [9:0] cnt_t;

  // Both totals must fit the 10-bit counters (at most 1024).
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_VIS    = cnt_t'(H_VISIBLE);
  localparam cnt_t V_VIS    = cnt_t'(V_VISIBLE);
  localparam cnt_t HS_FIRST = cnt_t'(H_VISIBLE + H_FP);
  localparam cnt_t HS_LAST  = cnt_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam cnt_t VS_FIRST = cnt_t'(V_VISIBLE + V_FP);
  localparam cnt_t VS_LAST  = cnt_t'(V_VISIBLE + V_FP + V_SYNC - 1);

  cnt_t x_q, x_d;
  cnt_t y_q, y_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic video_on_q, video_on_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  // Next counter values: advance only on a strobe, y steps when x wraps.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    x_d = x_q;
    y_d = y_q;
    if (pixel_en) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + cnt_t'(1);
      end else begin
        x_d = x_q + cnt_t'(1);
      end
    end
  end

  // Decode from the next counts so outputs update on the same edge as x/y.
  // With pixel_en low the counts hold, so the decodes hold too; the pulses
  // are qualified by pixel_en so they last exactly one original_clk cycle.
  always_comb begin
    hsync_d       = ~((x_d >= HS_FIRST) && (x_d <= HS_LAST));
    vsync_d       = ~((y_d >= VS_FIRST) && (y_d <= VS_LAST));
    video_on_d    = (x_d < H_VIS) && (y_d < V_VIS);
    line_start_d  = pixel_en && (x_d == '0);
    frame_start_d = pixel_en && (x_d == '0) && (y_d == '0);
  end

  // State and output registers; reset parks the counters on the last pixel of
  // the frame so the first strobe lands on (0,0) and starts a frame.
  always_ff @(posedge original_clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a default-timing instance for line-level
// behaviour and a small-timing instance for whole-frame behaviour.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       d_hs, d_vs, d_vid, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_hs, s_vs, s_vid, s_ls, s_fs;
  logic [9:0] s_x, s_y;

  vga_sync_gen u_dut (
    .original_clk(clk), .reset(rst), .pixel_en(en),
    .hsync(d_hs), .vsync(d_vs), .video_on(d_vid),
    .pixel_x(d_x), .pixel_y(d_y),
    .line_start(d_ls), .frame_start(d_fs)
  );

  // Small timing: H 10+2+3+1 = 16 (hsync low x=12..14), V 6+1+2+3 = 12 (vsync low y=7..8).
  vga_sync_gen #(
    .H_VISIBLE(10), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_VISIBLE(6),  .V_FP(1), .V_SYNC(2), .V_BP(3)
  ) u_small (
    .original_clk(clk), .reset(rst), .pixel_en(en),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_vid),
    .pixel_x(s_x), .pixel_y(s_y),
    .line_start(s_ls), .frame_start(s_fs)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; returns at the falling edge after the update edge.
  task automatic strobe();
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  // Strobes at one per four clocks.
  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      strobe();
      repeat (2) @(negedge clk);
    end
  endtask

  int bad, dec_bad, pw_bad, frz_bad, fsls_bad, vs_bad;
  int hs_cnt, hs_first, hs_last, vid_low, vid_first;
  int ls_cnt, ls_at, fs_cnt, vs_cnt, fs_first, fs_second;
  int ex, ey;
  logic prev_vs;
  logic [24:0] snap;

  initial begin
    // Reset with pixel_en held high: nothing may move.
    en = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_x", d_x, 799);
    check("rst_y", d_y, 524);
    check("rst_hsync", d_hs, 1);
    check("rst_vsync", d_vs, 1);
    check("rst_video_on", d_vid, 0);
    check("rst_line_start", d_ls, 0);
    check("rst_frame_start", d_fs, 0);
    check("small_rst_x", s_x, 15);
    check("small_rst_y", s_y, 11);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // First strobe after reset starts a frame.
    strobe();
    check("first_x", d_x, 0);
    check("first_y", d_y, 0);
    check("first_video_on", d_vid, 1);
    check("first_line_start", d_ls, 1);
    check("first_frame_start", d_fs, 1);
    check("first_hsync", d_hs, 1);
    check("first_vsync", d_vs, 1);
    @(negedge clk);
    check("first_ls_width", d_ls, 0);
    check("first_fs_width", d_fs, 0);
    check("first_x_hold", d_x, 0);
    @(negedge clk);

    // One full default line plus the wrap into line 1.
    bad = 0; pw_bad = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
    vid_low = 0; vid_first = -1; ls_cnt = 0; ls_at = -1; fs_cnt = 0;
    for (int i = 1; i <= 800; i++) begin
      strobe();
      if (d_x !== 10'(i % 800) || d_y !== 10'(i / 800)) bad++;
      if (d_hs === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(d_x);
        hs_last = int'(d_x);
      end
      if (d_vid === 1'b0) begin
        vid_low++;
        if (vid_first < 0) vid_first = int'(d_x);
      end
      if (d_ls === 1'b1) begin ls_cnt++; ls_at = i; end
      if (d_fs === 1'b1) fs_cnt++;
      @(negedge clk);
      if (d_ls !== 1'b0 || d_fs !== 1'b0 || d_x !== 10'(i % 800)) pw_bad++;
      @(negedge clk);
    end
    check("line_count_seq", bad, 0);
    check("line_hsync_low_strobes", hs_cnt, 96);
    check("line_hsync_first_x", hs_first, 656);
    check("line_hsync_last_x", hs_last, 751);
    check("line_video_off_strobes", vid_low, 160);
    check("line_video_off_first_x", vid_first, 640);
    check("line_start_count", ls_cnt, 1);
    check("line_start_period", ls_at, 800);
    check("line_no_frame_start", fs_cnt, 0);
    check("line_pulse_width", pw_bad, 0);
    check("line_wrap_y", d_y, 1);

    // Freeze mid-line at x=300.
    advance(300);
    check("freeze_x", d_x, 300);
    check("freeze_y", d_y, 1);
    snap = {d_hs, d_vs, d_vid, d_ls, d_fs, d_x, d_y};
    frz_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if ({d_hs, d_vs, d_vid, d_ls, d_fs, d_x, d_y} !== snap) frz_bad++;
    end
    check("freeze_hold", frz_bad, 0);
    strobe();
    check("resume_x", d_x, 301);
    check("resume_y", d_y, 1);
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-line at x=700.
    advance(399);
    check("pre_areset_x", d_x, 700);
    check("pre_areset_hsync", d_hs, 0);
    check("pre_areset_video_on", d_vid, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("areset_x", d_x, 799);
    check("areset_y", d_y, 524);
    check("areset_hsync", d_hs, 1);
    check("areset_vsync", d_vs, 1);
    check("areset_video_on", d_vid, 0);
    @(negedge clk);
    rst = 1'b0;

    // Full small frame, one strobe per four clocks, plus the wrap to (0,0).
    bad = 0; dec_bad = 0; pw_bad = 0; vs_bad = 0; vs_cnt = 0; ls_cnt = 0;
    fs_cnt = 0; fs_first = -1; fs_second = -1; fsls_bad = 0; prev_vs = s_vs;
    for (int i = 0; i <= 192; i++) begin
      strobe();
      ex = i % 16;
      ey = (i / 16) % 12;
      if (s_x !== 10'(ex) || s_y !== 10'(ey)) bad++;
      if (s_hs  !== ((ex >= 12 && ex <= 14) ? 1'b0 : 1'b1)) dec_bad++;
      if (s_vs  !== ((ey >= 7  && ey <= 8)  ? 1'b0 : 1'b1)) dec_bad++;
      if (s_vid !== ((ex < 10 && ey < 6) ? 1'b1 : 1'b0)) dec_bad++;
      if (s_ls  !== ((ex == 0) ? 1'b1 : 1'b0)) dec_bad++;
      if (s_fs  !== ((ex == 0 && ey == 0) ? 1'b1 : 1'b0)) dec_bad++;
      if (s_vs !== prev_vs && s_x !== 10'd0) vs_bad++;
      prev_vs = s_vs;
      if (s_vs === 1'b0) vs_cnt++;
      if (s_ls === 1'b1) ls_cnt++;
      if (s_fs === 1'b1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = i; else fs_second = i;
        if (s_ls !== 1'b1) fsls_bad++;
      end
      @(negedge clk);
      if (s_ls !== 1'b0 || s_fs !== 1'b0) pw_bad++;
      @(negedge clk);
    end
    check("frame_count_seq", bad, 0);
    check("frame_decode", dec_bad, 0);
    check("frame_vsync_low_strobes", vs_cnt, 32);
    check("frame_vsync_only_at_x0", vs_bad, 0);
    check("frame_line_starts", ls_cnt, 13);
    check("frame_frame_starts", fs_cnt, 2);
    check("frame_start_period", fs_second - fs_first, 192);
    check("frame_fs_with_ls", fsls_bad, 0);
    check("frame_pulse_width", pw_bad, 0);
    check("frame_wrap_y", s_y, 0);

    // Back-to-back strobes for one small frame.
    bad = 0; dec_bad = 0; ls_cnt = 0; fs_cnt = 0;
    @(negedge clk);
    en = 1'b1;
    for (int j = 1; j <= 192; j++) begin
      @(negedge clk);
      ex = j % 16;
      ey = (j / 16) % 12;
      if (s_x !== 10'(ex) || s_y !== 10'(ey)) bad++;
      if (s_hs  !== ((ex >= 12 && ex <= 14) ? 1'b0 : 1'b1)) dec_bad++;
      if (s_vs  !== ((ey >= 7  && ey <= 8)  ? 1'b0 : 1'b1)) dec_bad++;
      if (s_vid !== ((ex < 10 && ey < 6) ? 1'b1 : 1'b0)) dec_bad++;
      if (s_ls  !== ((ex == 0) ? 1'b1 : 1'b0)) dec_bad++;
      if (s_fs  !== ((ex == 0 && ey == 0) ? 1'b1 : 1'b0)) dec_bad++;
      if (s_ls === 1'b1) ls_cnt++;
      if (s_fs === 1'b1) fs_cnt++;
    end
    en = 1'b0;
    check("b2b_count_seq", bad, 0);
    check("b2b_decode", dec_bad, 0);
    check("b2b_line_starts", ls_cnt, 12);
    check("b2b_frame_starts", fs_cnt, 1);
    @(negedge clk);
    check("b2b_ls_drop", s_ls, 0);
    check("b2b_fs_drop", s_fs, 0);
    @(negedge clk);

    // Asynchronous reset mid-frame on the small instance at (11,4).
    advance(75);
    check("small_pre_areset_x", s_x, 11);
    check("small_pre_areset_y", s_y, 4);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("small_areset_x", s_x, 15);
    check("small_areset_y", s_y, 11);
    check("small_areset_hsync", s_hs, 1);
    check("small_areset_vsync", s_vs, 1);
    check("small_areset_video_on", s_vid, 0);
    check("small_areset_ls", s_ls, 0);
    en = 1'b1;
    repeat (3) @(negedge clk);
    check("small_rst_en_x", s_x, 15);
    check("small_rst_en_y", s_y, 11);
    en = 1'b0;
    rst = 1'b0;
    strobe();
    check("small_restart_x", s_x, 0);
    check("small_restart_y", s_y, 0);
    check("small_restart_fs", s_fs, 1);
    check("small_restart_ls", s_ls, 1);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
